matvec2_solve: RTL and testbench
================================

Name: matvec2_solve

Overview:
Sequential 2x2 matrix-vector multiplier directly downstream of the 2x2 matrix inverter. It consumes the inverse matrix, its error_line flag and a right-hand vector b, and produces x = inv * b. One shared signed multiplier is time-multiplexed over 4 MAC cycles. Valid/ready handshakes on both sides let it sit in the navigation solve pipeline.

Parameters:
DATA_WIDTH, 8, element width is W = DATA_WIDTH+1 bits, signed two's complement
FRAC_BITS, 4, number of fractional bits in the fixed-point format; 1.0 = 2^FRAC_BITS

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  inv/b/error_line valid
in_ready  output  1  block can accept an input
inv_flat  input  4*W  inverse matrix, row-major; element k at [k*W +: W] (k0=a, k1=b, k2=c, k3=d)
error_line  input  2  inverter error code; nonzero = singular matrix
b_flat  input  2*W  vector b; b0 at [0 +: W], b1 at [W +: W]
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
x_flat  output  2*W  result; x0 at [0 +: W], x1 at [W +: W]
out_err  output  2  error_line captured with this result

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1; out_valid=0; x_flat=0; out_err=0; accumulator and operand registers cleared.
- States: IDLE, MAC0, MAC1, MAC2, MAC3, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register inv, b and error_line. If error_line!=0, go to DONE with x=0 and out_err=error_line. Otherwise clear acc and go to MAC0.
- MAC0: acc = p(k0,b0). MAC1: x0 = sat(acc + p(k1,b1)); acc cleared. MAC2: acc = p(k2,b0). MAC3: x1 = sat(acc + p(k3,b1)); out_err=0; go to DONE.
- p(m,v): full 2W-bit signed product, arithmetic shift right by FRAC_BITS (truncation toward -inf). The sum is formed at 2W+1 bits. sat() clamps to [-2^(W-1), 2^(W-1)-1].
- DONE: out_valid=1; x_flat and out_err are stable while out_valid=1 and out_ready=0. On out_valid&&out_ready, go to IDLE; out_valid falls next cycle.
- in_ready=0 in every state except IDLE. There is no overlap: a new input is accepted only in IDLE.
- Latency, normal path: accept at edge N, MAC0..MAC3 at N+1..N+4, out_valid=1 from edge N+5. Error path: out_valid=1 from edge N+1.
- Throughput: at most one result per 6 cycles (normal path) or 2 cycles (error path), assuming out_ready=1.
- out_ready held 0 in DONE: the block stalls indefinitely with no loss of data.
- Input changes while in_ready=0 are ignored; only values captured at acceptance are used.
- Reset mid-operation: abort immediately to IDLE with all reset values; the partial result is discarded and no out_valid pulse is produced.
- x_flat holds its last value after handshake until it is overwritten at the next MAC1/MAC3 or error capture.

Test Plan:
- Identity: inv=[16,0,0,16], b=[32,-48], err=0 -> out_valid at acceptance+5, x=[32,-48], out_err=0.
- General: inv=[8,-4,2,16] (0.5,-0.25,0.125,1.0), b=[64,32] -> x0=32-8=24, x1=8+32=40.
- Saturation (W=9): inv=[16,16,-16,-16], b=[200,200] -> x0=255 (clamped from 400), x1=-256 (clamped from -400).
- Singular: error_line=2'b01, arbitrary inv/b -> out_valid at acceptance+1, x=[0,0], out_err=01, no MAC cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, x stable, in_ready=0. Release -> one handshake, then IDLE, in_ready=1. Back-to-back inputs with out_ready=1 -> one result per 6 cycles.
- Reset mid-operation: assert rst_n=0 during MAC2 -> out_valid=0, x=0, in_ready=1 immediately. After release, a new identity input gives a correct result.

Source files
------------

// File: rtl/matvec2_solve.sv
// matvec2_solve: x = inv * b on one shared signed multiplier over four MAC cycles,
// with valid/ready handshakes on both sides and singular-matrix bypass.
module matvec2_solve #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [4*(DATA_WIDTH+1)-1:0]   inv_flat,
    input  logic [1:0]                    error_line,
    input  logic [2*(DATA_WIDTH+1)-1:0]   b_flat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*(DATA_WIDTH+1)-1:0]   x_flat,
    output logic [1:0]                    out_err
);
    localparam int W = DATA_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, MAC3, DONE} state_t;

    state_t                r_state, w_next;
    logic [4*W-1:0]        r_inv;
    logic [2*W-1:0]        r_b;
    logic signed [2*W-1:0] r_acc;
    logic [2*W-1:0]        r_x;
    logic [1:0]            r_err;
    logic [W-1:0]          w_m, w_v;
    logic signed [2*W-1:0] w_prod, w_p;
    logic [2*W:0]          w_sum;
    logic                  w_ovf;
    logic [W-1:0]          w_sat;

    assign w_m = r_state == MAC0 ? r_inv[0+:W] :
                 r_state == MAC1 ? r_inv[W+:W] :
                 r_state == MAC2 ? r_inv[2*W+:W] : r_inv[3*W+:W];
    assign w_v = (r_state == MAC0 || r_state == MAC2) ? r_b[0+:W] : r_b[W+:W];
    // Sign-extended operands make the low 2W bits of the product the exact signed result
    assign w_prod = {{W{w_m[W-1]}}, w_m} * {{W{w_v[W-1]}}, w_v};
    assign w_p    = w_prod >>> FRAC_BITS;
    assign w_sum  = {r_acc[2*W-1], r_acc} + {w_p[2*W-1], w_p};
    assign w_ovf  = (|w_sum[2*W:W-1]) & ~(&w_sum[2*W:W-1]);
    assign w_sat  = w_ovf ? {w_sum[2*W], {(W-1){~w_sum[2*W]}}} : w_sum[W-1:0];

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign x_flat    = r_x;
    assign out_err   = r_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = |error_line ? DONE : MAC0;
            MAC0:    w_next = MAC1;
            MAC1:    w_next = MAC2;
            MAC2:    w_next = MAC3;
            MAC3:    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_inv   <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_x     <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (in_valid) begin
                    r_inv <= inv_flat;
                    r_b   <= b_flat;
                    r_acc <= '0;
                    if (|error_line) begin
                        r_x   <= '0;
                        r_err <= error_line;
                    end
                end
                MAC0, MAC2: r_acc <= w_p;
                MAC1: begin
                    r_x[0+:W] <= w_sat;
                    r_acc     <= '0;
                end
                MAC3: begin
                    r_x[W+:W] <= w_sat;
                    r_err     <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matvec2_solve.sv
// tb_matvec2_solve: randomized and directed checks of matvec2_solve against a
// transaction-level model with per-cycle handshake and result comparison.
module tb_matvec2_solve;
    localparam int DW = 8;
    localparam int FB = 4;
    localparam int W  = DW + 1;

    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid;
    logic [4*W-1:0] inv_flat = '0;
    logic [1:0] error_line = '0;
    logic [2*W-1:0] b_flat = '0;
    logic [2*W-1:0] x_flat;
    logic [1:0] out_err;
    int tests = 0, fails = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    matvec2_solve #(.DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inv_flat(inv_flat), .error_line(error_line), .b_flat(b_flat),
        .out_valid(out_valid), .out_ready(out_ready), .x_flat(x_flat), .out_err(out_err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        int hi = (1 << (W - 1)) - 1;
        return v > hi ? hi : (v < -hi - 1 ? -hi - 1 : v);
    endfunction

    function automatic int el(input logic [4*W-1:0] f, input int k);
        return int'($signed(f[k*W +: W]));
    endfunction

    function automatic int prod(input int m, input int v);
        return (m * v) >>> FB;
    endfunction

    function automatic logic [2*W-1:0] model_x(input logic [4*W-1:0] inv, input logic [2*W-1:0] b);
        logic [4*W-1:0] bb = {{(2*W){1'b0}}, b};
        int x0 = sat(prod(el(inv, 0), el(bb, 0)) + prod(el(inv, 1), el(bb, 1)));
        int x1 = sat(prod(el(inv, 2), el(bb, 0)) + prod(el(inv, 3), el(bb, 1)));
        return {W'(x1), W'(x0)};
    endfunction

    function automatic logic [4*W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    function automatic logic [2*W-1:0] pack2(input int a, input int b);
        return {W'(b), W'(a)};
    endfunction

    // Transaction-level reference: idle / busy countdown / holding a result
    logic m_idle = 1, m_valid = 0;
    int m_cnt = 0;
    logic [2*W-1:0] m_x = '0, m_pend = '0;
    logic [1:0] m_err = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1; m_valid <= 0; m_cnt <= 0; m_x <= '0; m_err <= '0;
        end else if (m_valid) begin
            if (out_ready) begin m_valid <= 0; m_idle <= 1; end
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle <= 0;
                if (|error_line) begin
                    m_valid <= 1; m_x <= '0; m_err <= error_line;
                end else begin
                    m_cnt <= 4; m_pend <= model_x(inv_flat, b_flat);
                end
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin m_valid <= 1; m_x <= m_pend; m_err <= '0; end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(m_idle));
        chk("out_valid", int'(out_valid), int'(m_valid));
        if (m_valid) begin
            chk("x_flat", int'(x_flat), int'(m_x));
            chk("out_err", int'(out_err), int'(m_err));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic run(input string nm, input logic [4*W-1:0] inv, input logic [2*W-1:0] b,
                       input logic [1:0] e, input int ex0, input int ex1, input int elat);
        int lat = 0;
        logic [2*W-1:0] mx;
        wait_idle();
        inv_flat = inv; b_flat = b; error_line = e; in_valid = 1; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        inv_flat = (4*W)'({$urandom(), $urandom()});
        b_flat = (2*W)'($urandom());
        error_line = 2'($urandom());
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 50);
        chk({nm, "_lat"}, lat, elat);
        chk({nm, "_x0"}, int'($signed(x_flat[W-1:0])), ex0);
        chk({nm, "_x1"}, int'($signed(x_flat[2*W-1:W])), ex1);
        chk({nm, "_err"}, int'(out_err), int'(e));
        if (e == 0) begin
            mx = model_x(inv, b);
            chk({nm, "_model_x0"}, int'($signed(mx[W-1:0])), ex0);
            chk({nm, "_model_x1"}, int'($signed(mx[2*W-1:W])), ex1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2*W-1:0] held;
        int stamp, prev, n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_x", int'(x_flat), 0);
        chk("rst_err", int'(out_err), 0);
        rst_n = 1;
        @(posedge clk); #1;

        run("identity", pack4(16, 0, 0, 16), pack2(32, -48), 2'b00, 32, -48, 5);
        run("general", pack4(8, -4, 2, 16), pack2(64, 32), 2'b00, 24, 40, 5);
        run("saturate", pack4(16, 16, -16, -16), pack2(200, 200), 2'b00, 255, -256, 5);
        run("singular", pack4(5, 6, 7, 8), pack2(9, 10), 2'b01, 0, 0, 1);
        run("singular3", pack4(-1, 2, 3, 4), pack2(1, 1), 2'b11, 0, 0, 1);

        // Backpressure: hold the result for ten cycles
        wait_idle();
        inv_flat = pack4(8, -4, 2, 16); b_flat = pack2(64, 32); error_line = 0;
        in_valid = 1; out_ready = 0;
        @(posedge clk); #1 in_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 50);
        held = x_flat;
        chk("bp_x_start", int'(held), int'(pack2(24, 40)));
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_x_stable", int'(x_flat), int'(held));
        end
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready), 1);

        // Back-to-back normal inputs: one result every six cycles
        @(posedge clk); #1;
        wait_idle();
        in_valid = 1; error_line = 0; out_ready = 1;
        inv_flat = (4*W)'({$urandom(), $urandom()}); b_flat = (2*W)'($urandom());
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!out_valid && n < 50);
            stamp = cyc;
            if (i > 0) chk("b2b_interval", stamp - prev, 6);
            prev = stamp;
            @(posedge clk); #1;
            inv_flat = (4*W)'({$urandom(), $urandom()}); b_flat = (2*W)'($urandom());
        end
        in_valid = 0;

        // Reset during MAC2 discards the partial result
        wait_idle();
        inv_flat = pack4(16, 0, 0, 16); b_flat = pack2(32, -48); error_line = 0; in_valid = 1;
        @(posedge clk); #1 in_valid = 0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_x", int'(x_flat), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        run("post_rst", pack4(16, 0, 0, 16), pack2(32, -48), 2'b00, 32, -48, 5);

        // Randomized traffic with random backpressure and input churn
        for (int i = 0; i < 800; i++) begin
            in_valid = 1'($urandom());
            out_ready = ($urandom() % 4) != 0;
            inv_flat = (4*W)'({$urandom(), $urandom()});
            b_flat = (2*W)'($urandom());
            error_line = ($urandom() % 5 == 0) ? 2'($urandom()) : 2'b00;
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
